pipeline_hazard_sequencer: RTL and testbench
============================================

Name: pipeline_hazard_sequencer

Overview:
Central stall/flush controller for the 5-stage PipelinedARMv8 core (IF, ID, EX, MEM, WB).
- Owns the write-enables and flushes of PC, IF/ID, ID/EX and EX/MEM.
- Sequences boot hold-off after reset, load-use stalls, taken-branch flushes, data-memory wait states, and a fatal memory-timeout halt.
- Sits beside the datapath; stage registers consume its enables directly.

Parameters:
BOOT_CYCLES, 2, cycles the pipeline is held frozen after reset release
MEM_TIMEOUT, 16, max consecutive dmem wait cycles before HALT
REG_ZERO, 31, register index treated as XZR (never a hazard source)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
id_rn  in  5  Rn field of instruction in ID
id_rm  in  5  Rm field of instruction in ID
id_uses_rm  in  1  ID instruction reads Rm (R-type, STUR, CBZ)
ex_rd  in  5  destination of instruction in EX
ex_mem_read  in  1  EX instruction is LDUR
branch_taken  in  1  branch resolved taken in MEM (B, BR, CBZ, B.cond)
dmem_req  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register enable
idex_write  out  1  ID/EX register enable
exmem_write  out  1  EX/MEM register enable
ifid_flush  out  1  zero IF/ID (NOP)
idex_flush  out  1  zero ID/EX control bits
exmem_flush  out  1  zero EX/MEM control bits
halted  out  1  sticky timeout error
ctrl_state  out  2  BOOT=0, RUN=1, MEM_WAIT=2, HALT=3
stall_count  out  32  stall cycles (optional feature)
flush_count  out  32  branch flushes (optional feature)

Behaviour:
- Reset (async, reset=0): state=BOOT, boot counter=0, wait counter=0, halted=0. All *_write=0, all *_flush=1, counters=0.
- BOOT: all writes 0, flushes 1. After BOOT_CYCLES clocks with reset=1, go to RUN. BOOT_CYCLES=0 means RUN on the first edge.
- RUN: default is all writes 1, flushes 0. Events are checked in priority order; outputs are combinational from state and inputs.
  1. branch_taken:
     - pc_write=1; ifid_flush=idex_flush=exmem_flush=1.
     - Overrides load-use.
     - flush_count++.
     - Stay in RUN.
  2. dmem_req && !dmem_ready:
     - All writes 0, no flush.
     - Next state MEM_WAIT, wait counter=1.
     - stall_count++.
  3. Load-use: ex_mem_read && ex_rd!=REG_ZERO && (ex_rd==id_rn || (id_uses_rm && ex_rd==id_rm)).
     - pc_write=0, ifid_write=0, idex_flush=1; EX/MEM advances.
     - stall_count++.
     - Exactly one bubble per hazard.
- MEM_WAIT:
  - All writes 0.
  - dmem_ready=1: return to RUN, writes resume next cycle.
  - Otherwise wait counter++. Reaching MEM_TIMEOUT goes to HALT.
  - branch_taken is ignored here (MEM is frozen, so it cannot be new).
  - stall_count++ each cycle.
- HALT: all writes 0, flushes 0, halted=1. Exit only by reset.
- Simultaneous branch_taken and dmem wait in RUN: the branch wins, since the flushed instruction does not own the memory access.
- Reset mid-MEM_WAIT or HALT: immediate return to BOOT.
- Counters saturate at 2^32-1 (no wrap).

Optional Feature:
PIPELINE_PERF_COUNTERS_EN
- Defined: stall_count and flush_count are live registers as above.
- Undefined: both ports are tied to 0 and no counter flops are inferred.
- Control behaviour is identical either way.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state encoding constants (BOOT/RUN/MEM_WAIT/HALT);
  - REG_ZERO = 31;
  - register-index width (5).
- One sub-module, hazard_detect: purely combinational load-use compare (id_rn, id_rm, id_uses_rm, ex_rd, ex_mem_read -> load_use). It is reused by the forwarding unit.

Test Plan:
- Reset low 15 ns then high, BOOT_CYCLES=2 -> ctrl_state 0 for 2 edges, then 1; pc_write rises on the 3rd edge.
- LDUR X2 in EX, ADD X3,X2,X18 in ID -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_count=1.
- LDUR with ex_rd=31, ID reads X31 -> no stall, all writes 1.
- branch_taken=1 together with a load-use hazard -> three flushes=1, pc_write=1, no stall; flush_count=1.
- dmem_req=1, dmem_ready low 3 cycles then high -> MEM_WAIT for 3 cycles, writes 0, then RUN; stall_count=3.
- dmem_ready held low 16 cycles -> halted=1, state 3. Async reset asserted mid-HALT -> BOOT immediately, halted=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: state codes,
// register-index width, the XZR index and a saturating counter helper.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int PERF_CNT_W = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd31;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } ctrl_state_e;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
    return (value == '1) ? value : value + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_hazard_detect.sv
// Combinational load-use detector: an LDUR in EX whose destination is read by
// the instruction in ID. XZR is never a hazard source.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rn_i,
  input  logic [REG_IDX_W-1:0] id_rm_i,
  input  logic                 id_uses_rm_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 ex_mem_read_i,
  output logic                 load_use_o
);

  logic rnMatch;
  logic rmMatch;

  assign rnMatch    = (ex_rd_i == id_rn_i);
  assign rmMatch    = id_uses_rm_i && (ex_rd_i == id_rm_i);
  assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (rnMatch || rmMatch);

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central stall/flush sequencer for the 5-stage core. Defining
// PIPELINE_PERF_COUNTERS_EN makes stall_count/flush_count live counters.
module pipeline_hazard_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_IDX_W-1:0]  id_rn,
  input  logic [REG_IDX_W-1:0]  id_rm,
  input  logic                  id_uses_rm,
  input  logic [REG_IDX_W-1:0]  ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  exmem_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  halted,
  output logic [1:0]            ctrl_state,
  output logic [PERF_CNT_W-1:0] stall_count,
  output logic [PERF_CNT_W-1:0] flush_count
);

  localparam int BOOT_W = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lu_bubble_q, lu_bubble_d;

  logic loadUse;
  logic luStall;
  logic memMiss;

  hazard_detect u_hazard_detect (
    .id_rn_i       (id_rn),
    .id_rm_i       (id_rm),
    .id_uses_rm_i  (id_uses_rm),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (loadUse)
  );

  // A bubble was just inserted for this load, so the same hazard must not stall twice.
  assign luStall = loadUse && !lu_bubble_q;
  assign memMiss = dmem_req && !dmem_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      lu_bubble_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      lu_bubble_q <= lu_bubble_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    lu_bubble_d = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      ST_RUN: begin
        // A taken branch flushes the instruction that owns any pending access.
        if (branch_taken) begin
          state_d = ST_RUN;
        end else if (memMiss) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (luStall) begin
          lu_bubble_d = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      ST_RUN: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (memMiss) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
        end else if (luStall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign halted     = (state_q == ST_HALT);
  assign ctrl_state = state_q;

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic                  stallEvent;
  logic                  flushEvent;
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Wait states count only while memory is still not ready.
  assign stallEvent = ((state_q == ST_RUN) && !branch_taken && (memMiss || luStall)) ||
                      ((state_q == ST_MEM_WAIT) && !dmem_ready);
  assign flushEvent = (state_q == ST_RUN) && branch_taken;

  assign stall_cnt_d = stallEvent ? sat_inc(stall_cnt_q) : stall_cnt_q;
  assign flush_cnt_d = flushEvent ? sat_inc(flush_cnt_q) : flush_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer; counter expectations follow
// PIPELINE_PERF_COUNTERS_EN (zero when the feature is compiled out).
module tb_pipeline_hazard_sequencer;

`ifdef PIPELINE_PERF_COUNTERS_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic       clock        = 1'b1;
  logic       reset        = 1'b0;
  logic [4:0] id_rn        = '0;
  logic [4:0] id_rm        = '0;
  logic       id_uses_rm   = 1'b0;
  logic [4:0] ex_rd        = '0;
  logic       ex_mem_read  = 1'b0;
  logic       branch_taken = 1'b0;
  logic       dmem_req     = 1'b0;
  logic       dmem_ready   = 1'b0;

  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        halted;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_count, flush_count;

  logic [3:0] wr;
  logic [2:0] fl;

  int vectors     = 0;
  int miscompares = 0;
  int expStall    = 0;
  int expFlush    = 0;

  assign wr = {pc_write, ifid_write, idex_write, exmem_write};
  assign fl = {ifid_flush, idex_flush, exmem_flush};

  pipeline_hazard_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rm   (id_uses_rm),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .exmem_write  (exmem_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .halted       (halted),
    .ctrl_state   (ctrl_state),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  // Rising edges fall at 10, 20, 30 ...; inputs change and outputs are sampled after falling edges.
  always #5 clock = ~clock;

  task automatic nextCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clearInputs();
    id_rn        = '0;
    id_rm        = '0;
    id_uses_rm   = 1'b0;
    ex_rd        = '0;
    ex_mem_read  = 1'b0;
    branch_taken = 1'b0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
  endtask

  task automatic test_reset();
    #8;
    vectors++;
    if (ctrl_state !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_state got=%0d want=0", ctrl_state); end
    vectors++;
    if (wr !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_writes got=%b want=0000", wr); end
    vectors++;
    if (fl !== 3'b111) begin miscompares++; $display("[TB] FAIL reset_flushes got=%b want=111", fl); end
    vectors++;
    if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halted got=%b want=0", halted); end
    vectors++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      miscompares++; $display("[TB] FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
    end
    #7 reset = 1'b1;
  endtask

  task automatic test_boot();
    for (int i = 1; i <= 2; i++) begin
      nextCycle(); #1;
      vectors++;
      if (ctrl_state !== 2'd0 || pc_write !== 1'b0) begin
        miscompares++; $display("[TB] FAIL boot_edge%0d state=%0d pc_write=%b want state=0 pc_write=0", i, ctrl_state, pc_write);
      end
    end
    nextCycle(); #1;
    vectors++;
    if (ctrl_state !== 2'd1) begin miscompares++; $display("[TB] FAIL boot_run_state got=%0d want=1", ctrl_state); end
    vectors++;
    if (wr !== 4'b1111 || fl !== 3'b000) begin
      miscompares++; $display("[TB] FAIL boot_run_outputs writes=%b flushes=%b want 1111/000", wr, fl);
    end
  endtask

  task automatic test_load_use();
    // LDUR X2 in EX, ADD X3,X2,X18 in ID, held for two cycles: only one bubble.
    ex_mem_read = 1'b1; ex_rd = 5'd2; id_rn = 5'd2; id_rm = 5'd18; id_uses_rm = 1'b1;
    #1;
    vectors++;
    if (wr !== 4'b0011 || fl !== 3'b010) begin
      miscompares++; $display("[TB] FAIL lu_rn_stall writes=%b flushes=%b want 0011/010", wr, fl);
    end
    expStall++;
    nextCycle(); #1;
    vectors++;
    if (wr !== 4'b1111 || fl !== 3'b000) begin
      miscompares++; $display("[TB] FAIL lu_single_bubble writes=%b flushes=%b want 1111/000", wr, fl);
    end
    nextCycle();
    clearInputs();
    // Hazard through Rm only.
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rn = 5'd5; id_rm = 5'd7; id_uses_rm = 1'b1;
    #1;
    vectors++;
    if (wr !== 4'b0011 || fl !== 3'b010) begin
      miscompares++; $display("[TB] FAIL lu_rm_stall writes=%b flushes=%b want 0011/010", wr, fl);
    end
    expStall++;
    nextCycle();
    clearInputs();
    // Rm matches but the instruction does not read Rm.
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rn = 5'd5; id_rm = 5'd7; id_uses_rm = 1'b0;
    #1;
    vectors++;
    if (wr !== 4'b1111) begin miscompares++; $display("[TB] FAIL lu_rm_unused writes=%b want 1111", wr); end
    nextCycle();
    clearInputs();
    // Rn matches but EX is not a load.
    ex_mem_read = 1'b0; ex_rd = 5'd9; id_rn = 5'd9;
    #1;
    vectors++;
    if (wr !== 4'b1111) begin miscompares++; $display("[TB] FAIL lu_not_load writes=%b want 1111", wr); end
    nextCycle();
    clearInputs();
    #1;
    vectors++;
    if (stall_count !== (PerfEn ? 32'(expStall) : 32'd0)) begin
      miscompares++; $display("[TB] FAIL lu_stall_count got=%0d want=%0d", stall_count, PerfEn ? expStall : 0);
    end
  endtask

  task automatic test_zero_reg();
    ex_mem_read = 1'b1; ex_rd = 5'd31; id_rn = 5'd31; id_rm = 5'd31; id_uses_rm = 1'b1;
    #1;
    vectors++;
    if (wr !== 4'b1111 || fl !== 3'b000) begin
      miscompares++; $display("[TB] FAIL xzr_no_stall writes=%b flushes=%b want 1111/000", wr, fl);
    end
    nextCycle();
    clearInputs();
  endtask

  task automatic test_branch();
    // Taken branch together with a load-use hazard.
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd2; id_rn = 5'd2;
    #1;
    vectors++;
    if (wr !== 4'b1111 || fl !== 3'b111) begin
      miscompares++; $display("[TB] FAIL br_over_lu writes=%b flushes=%b want 1111/111", wr, fl);
    end
    expFlush++;
    nextCycle();
    clearInputs();
    // Taken branch together with a dmem wait.
    branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    vectors++;
    if (wr !== 4'b1111 || fl !== 3'b111) begin
      miscompares++; $display("[TB] FAIL br_over_mem writes=%b flushes=%b want 1111/111", wr, fl);
    end
    expFlush++;
    nextCycle();
    clearInputs();
    #1;
    vectors++;
    if (ctrl_state !== 2'd1) begin miscompares++; $display("[TB] FAIL br_stays_run state=%0d want=1", ctrl_state); end
    vectors++;
    if (flush_count !== (PerfEn ? 32'(expFlush) : 32'd0)) begin
      miscompares++; $display("[TB] FAIL br_flush_count got=%0d want=%0d", flush_count, PerfEn ? expFlush : 0);
    end
    vectors++;
    if (stall_count !== (PerfEn ? 32'(expStall) : 32'd0)) begin
      miscompares++; $display("[TB] FAIL br_stall_count got=%0d want=%0d", stall_count, PerfEn ? expStall : 0);
    end
  endtask

  task automatic test_mem_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    vectors++;
    if (wr !== 4'b0000 || fl !== 3'b000 || ctrl_state !== 2'd1) begin
      miscompares++; $display("[TB] FAIL mw_detect writes=%b flushes=%b state=%0d want 0000/000/1", wr, fl, ctrl_state);
    end
    for (int i = 2; i <= 4; i++) begin
      nextCycle();
      if (i == 4) dmem_ready = 1'b1;
      #1;
      vectors++;
      if (ctrl_state !== 2'd2 || wr !== 4'b0000) begin
        miscompares++; $display("[TB] FAIL mw_cycle%0d state=%0d writes=%b want 2/0000", i, ctrl_state, wr);
      end
    end
    expStall += 3;
    nextCycle();
    clearInputs();
    #1;
    vectors++;
    if (ctrl_state !== 2'd1 || wr !== 4'b1111) begin
      miscompares++; $display("[TB] FAIL mw_resume state=%0d writes=%b want 1/1111", ctrl_state, wr);
    end
    vectors++;
    if (stall_count !== (PerfEn ? 32'(expStall) : 32'd0)) begin
      miscompares++; $display("[TB] FAIL mw_stall_count got=%0d want=%0d", stall_count, PerfEn ? expStall : 0);
    end
  endtask

  task automatic test_timeout();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      nextCycle(); #1;
      vectors++;
      if (ctrl_state !== 2'd2) begin
        miscompares++; $display("[TB] FAIL to_wait%0d state=%0d want=2", i, ctrl_state);
      end
    end
    nextCycle(); #1;
    expStall += 16;
    vectors++;
    if (ctrl_state !== 2'd3 || halted !== 1'b1) begin
      miscompares++; $display("[TB] FAIL to_halt state=%0d halted=%b want 3/1", ctrl_state, halted);
    end
    vectors++;
    if (stall_count !== (PerfEn ? 32'(expStall) : 32'd0)) begin
      miscompares++; $display("[TB] FAIL to_stall_count got=%0d want=%0d", stall_count, PerfEn ? expStall : 0);
    end
    // HALT ignores memory completion and branches.
    dmem_ready = 1'b1; branch_taken = 1'b1;
    #1;
    vectors++;
    if (wr !== 4'b0000 || fl !== 3'b000) begin
      miscompares++; $display("[TB] FAIL halt_outputs writes=%b flushes=%b want 0000/000", wr, fl);
    end
    nextCycle(); #1;
    vectors++;
    if (ctrl_state !== 2'd3 || flush_count !== (PerfEn ? 32'(expFlush) : 32'd0)) begin
      miscompares++; $display("[TB] FAIL halt_sticky state=%0d flush_count=%0d want 3/%0d", ctrl_state, flush_count, PerfEn ? expFlush : 0);
    end
    // Asynchronous reset mid-HALT, checked before any clock edge.
    reset = 1'b0;
    #1;
    vectors++;
    if (ctrl_state !== 2'd0 || halted !== 1'b0) begin
      miscompares++; $display("[TB] FAIL halt_reset state=%0d halted=%b want 0/0", ctrl_state, halted);
    end
    vectors++;
    if (wr !== 4'b0000 || fl !== 3'b111 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
      miscompares++; $display("[TB] FAIL halt_reset_outputs writes=%b flushes=%b counts=%0d/%0d want 0000/111/0/0", wr, fl, stall_count, flush_count);
    end
    expStall = 0;
    expFlush = 0;
    clearInputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) nextCycle();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    nextCycle(); #1;
    vectors++;
    if (ctrl_state !== 2'd2) begin miscompares++; $display("[TB] FAIL rmw_enter state=%0d want=2", ctrl_state); end
    reset = 1'b0;
    #1;
    vectors++;
    if (ctrl_state !== 2'd0 || fl !== 3'b111) begin
      miscompares++; $display("[TB] FAIL rmw_reset state=%0d flushes=%b want 0/111", ctrl_state, fl);
    end
    clearInputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_boot();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
